// File: rtl/div_ctrl.sv
// div_ctrl: sequences DIV/DIVU/REM/REMU(W) onto the multi-cycle divider.
// Handles divide-by-zero and signed overflow locally; drains on flush.
module div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        flush,
  output logic [63:0] result,
  output logic        done,
  output logic        busy,
  output logic        div_valid,
  output logic        div_signed,
  output logic [63:0] div_a,
  output logic [63:0] div_b,
  input  logic [63:0] div_quot,
  input  logic [63:0] div_rem,
  input  logic        div_data_ok
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  op_q;
  logic [63:0] prep_a;
  logic [63:0] prep_b;
  logic [63:0] min_neg;
  logic        b_zero;
  logic        ovf;
  logic        accept;
  logic        load_spec;
  logic        load_div;
  logic [63:0] spec_sel;
  logic [63:0] div_sel;

  function automatic logic [63:0] fmt(
    input logic        word,
    input logic [63:0] v
  );
    return word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    prep_a  = a;
    prep_b  = b;
    min_neg = 64'h8000_0000_0000_0000;
    if (op[2]) begin
      prep_a  = op[0] ? {32'b0, a[31:0]}
                      : {{32{a[31]}}, a[31:0]};
      prep_b  = op[0] ? {32'b0, b[31:0]}
                      : {{32{b[31]}}, b[31:0]};
      min_neg = 64'hFFFF_FFFF_8000_0000;
    end
  end

  assign b_zero = (prep_b == 64'd0);
  assign ovf    = ~op[0] & (prep_a == min_neg)
                & (&prep_b);
  assign accept = (state == S_IDLE) & req & ~flush;

  always_comb begin
    spec_sel = prep_a;
    unique case (1'b1)
      b_zero & op[1]:  spec_sel = prep_a;
      b_zero & ~op[1]: spec_sel = '1;
      ~b_zero & op[1]: spec_sel = 64'd0;
      default:         spec_sel = prep_a;
    endcase
  end

  assign div_sel = op_q[1] ? div_rem : div_quot;

  always_comb begin
    state_nx  = state;
    load_spec = 1'b0;
    load_div  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (b_zero | ovf) begin
            state_nx  = S_DONE;
            load_spec = 1'b1;
          end else begin
            state_nx  = S_RUN;
          end
        end
      end
      S_RUN: begin
        // flush racing completion still discards the result
        if (div_data_ok) begin
          if (flush) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DONE;
            load_div = 1'b1;
          end
        end else if (flush) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_data_ok) state_nx = S_IDLE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign div_valid = (state == S_RUN)
                   | (state == S_DRAIN);
  assign busy      = ~reset & (div_valid | accept);
  assign done      = (state == S_DONE) & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= 3'd0;
      div_a      <= 64'd0;
      div_b      <= 64'd0;
      div_signed <= 1'b0;
      result     <= 64'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        div_a      <= prep_a;
        div_b      <= prep_b;
        div_signed <= ~op[0];
        op_q       <= op;
      end
      if (load_spec) result <= fmt(op[2], spec_sel);
      if (load_div)  result <= fmt(op_q[2], div_sel);
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed + random checks of div_ctrl against a
// RISC-V divide reference model and a behavioural divider.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic        flush = 1'b0;
  logic [63:0] result;
  logic        done;
  logic        busy;
  logic        div_valid;
  logic        div_signed;
  logic [63:0] div_a;
  logic [63:0] div_b;
  logic [63:0] div_quot;
  logic [63:0] div_rem;
  logic        div_data_ok;

  int checks = 0;
  int failures = 0;
  int lat_force = -1;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  div_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .op(op),
    .a(a), .b(b), .flush(flush), .result(result),
    .done(done), .busy(busy), .div_valid(div_valid),
    .div_signed(div_signed), .div_a(div_a),
    .div_b(div_b), .div_quot(div_quot),
    .div_rem(div_rem), .div_data_ok(div_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(
    input logic [2:0]  o,
    input logic [63:0] x,
    input logic [63:0] y
  );
    logic [31:0] x32, y32, q32, r32, v32;
    logic signed [31:0] sx32, sy32;
    logic [63:0] q, r;
    logic signed [63:0] sx, sy;
    if (o[2]) begin
      x32 = x[31:0];
      y32 = y[31:0];
      sx32 = x32;
      sy32 = y32;
      if (y32 == 32'd0) begin
        q32 = '1; r32 = x32;
      end else if (!o[0] && x32 == 32'h8000_0000
                   && y32 == 32'hFFFF_FFFF) begin
        q32 = x32; r32 = 32'd0;
      end else if (o[0]) begin
        q32 = x32 / y32; r32 = x32 % y32;
      end else begin
        q32 = sx32 / sy32; r32 = sx32 % sy32;
      end
      v32 = o[1] ? r32 : q32;
      return {{32{v32[31]}}, v32};
    end
    sx = x;
    sy = y;
    if (y == 64'd0) begin
      q = '1; r = x;
    end else if (!o[0] && x == MIN64 && (&y)) begin
      q = x; r = 64'd0;
    end else if (o[0]) begin
      q = x / y; r = x % y;
    end else begin
      q = sx / sy; r = sx % sy;
    end
    return o[1] ? r : q;
  endfunction

  // behavioural divider: random latency, one-cycle data_ok pulse
  initial begin
    int cnt;
    int lat;
    logic signed [63:0] sa, sb;
    cnt = 0;
    lat = 0;
    div_data_ok = 1'b0;
    div_quot = 64'd0;
    div_rem = 64'd0;
    forever begin
      @(negedge clk);
      if (reset || div_data_ok) begin
        div_data_ok = 1'b0;
        cnt = 0;
      end else if (div_valid) begin
        if (cnt == 0)
          lat = (lat_force >= 0) ? lat_force
                                 : int'($urandom_range(0, 4));
        if (cnt >= lat) begin
          sa = div_a;
          sb = div_b;
          if (div_b == 64'd0) begin
            div_quot = '1; div_rem = div_a;
          end else if (div_signed && div_a == MIN64
                       && (&div_b)) begin
            div_quot = div_a; div_rem = 64'd0;
          end else if (div_signed) begin
            div_quot = sa / sb; div_rem = sa % sb;
          end else begin
            div_quot = div_a / div_b;
            div_rem = div_a % div_b;
          end
          div_data_ok = 1'b1;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic run_op(input logic [2:0] o,
                        input logic [63:0] x,
                        input logic [63:0] y,
                        output logic [63:0] res);
    logic [63:0] exp, pa, pb;
    logic special, prev_ok, seen_valid, bad_valid;
    int cyc;
    exp = ref_div(o, x, y);
    if (o[2]) begin
      special = (y[31:0] == 32'd0) ||
                (!o[0] && x[31:0] == 32'h8000_0000 &&
                 y[31:0] == 32'hFFFF_FFFF);
      pa = o[0] ? {32'd0, x[31:0]} : {{32{x[31]}}, x[31:0]};
      pb = o[0] ? {32'd0, y[31:0]} : {{32{y[31]}}, y[31:0]};
    end else begin
      special = (y == 64'd0) ||
                (!o[0] && x == MIN64 && (&y));
      pa = x;
      pb = y;
    end
    @(negedge clk);
    chk1("idle_done_low", done, 1'b0);
    chk1("idle_valid_low", div_valid, 1'b0);
    req = 1'b1; op = o; a = x; b = y;
    #1;
    chk1("accept_busy", busy, 1'b1);
    cyc = 0;
    prev_ok = 1'b0;
    seen_valid = 1'b0;
    bad_valid = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
      if (done) break;
      if (cyc == 1 && !special) begin
        chk64("div_a", div_a, pa);
        chk64("div_b", div_b, pb);
        chk1("div_signed", div_signed, ~o[0]);
      end
      if (div_valid) seen_valid = 1'b1;
      else bad_valid = 1'b1;
      prev_ok = div_data_ok;
    end
    chk1("done_seen", done, 1'b1);
    chk64("result", result, exp);
    res = result;
    if (special) begin
      chk64("special_latency", 64'(cyc), 64'd1);
      chk1("special_no_valid", seen_valid, 1'b0);
    end else begin
      chk1("ok_then_done", prev_ok, 1'b1);
      chk1("valid_held", bad_valid, 1'b0);
    end
    chk1("done_valid_low", div_valid, 1'b0);
    chk1("done_busy_low", busy, 1'b0);
    req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic bad;
    int n;
    #2;
    reset = 1'b1;
    #1;
    chk64("rst_result", result, 64'd0);
    chk64("rst_div_a", div_a, 64'd0);
    chk64("rst_div_b", div_b, 64'd0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", div_valid, 1'b0);
    chk1("rst_signed", div_signed, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(3'b000, -64'sd7, 64'd2, r);
    chk64("div_m7_2", r, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'b010, -64'sd7, 64'd2, r);
    chk64("rem_m7_2", r, '1);
    run_op(3'b001, 64'd123, 64'd0, r);
    chk64("divu_by0", r, '1);
    run_op(3'b011, 64'd123, 64'd0, r);
    chk64("remu_by0", r, 64'd123);
    run_op(3'b000, MIN64, '1, r);
    chk64("div_ovf", r, MIN64);
    run_op(3'b100, 64'h8000_0000, 64'hFFFF_FFFF, r);
    chk64("divw_ovf", r, 64'hFFFF_FFFF_8000_0000);
    run_op(3'b110, 64'h8000_0000, 64'hFFFF_FFFF, r);
    chk64("remw_ovf", r, 64'd0);
    run_op(3'b101, 64'hDEAD_0000_FFFF_FFFE, 64'd1, r);
    chk64("divuw", r, 64'hFFFF_FFFF_FFFF_FFFE);

    // flush in RUN, then drain
    lat_force = 3;
    @(negedge clk);
    req = 1'b1; op = 3'b000; a = 64'd100; b = 64'd7;
    @(negedge clk);
    #1;
    chk1("flush_run_valid", div_valid, 1'b1);
    flush = 1'b1;
    req = 1'b0;
    @(negedge clk);
    #1;
    flush = 1'b0;
    bad = 1'b0;
    n = 0;
    while (n < 20) begin
      if (!div_valid) break;
      if (!busy || done) bad = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    chk1("drain_ended", div_valid, 1'b0);
    chk1("drain_busy_valid", bad, 1'b0);
    chk1("drain_no_done", done, 1'b0);
    chk1("drain_idle_busy", busy, 1'b0);
    lat_force = -1;
    run_op(3'b000, 64'd100, 64'd7, r);
    chk64("after_flush", r, 64'd14);

    // flush coinciding with data_ok
    lat_force = 2;
    @(negedge clk);
    req = 1'b1; op = 3'b010; a = 64'd50; b = 64'd7;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      #1;
      n++;
      if (div_data_ok) break;
    end
    chk1("race_ok_seen", div_data_ok, 1'b1);
    flush = 1'b1;
    req = 1'b0;
    @(negedge clk);
    #1;
    chk1("race_no_done", done, 1'b0);
    chk1("race_valid", div_valid, 1'b0);
    chk1("race_busy", busy, 1'b0);
    flush = 1'b0;
    lat_force = -1;

    // flush in DONE suppresses done
    @(negedge clk);
    req = 1'b1; op = 3'b011; a = 64'd5; b = 64'd0;
    @(negedge clk);
    #1;
    chk1("done_pre_flush", done, 1'b1);
    flush = 1'b1;
    #1;
    chk1("done_flushed", done, 1'b0);
    @(negedge clk);
    req = 1'b0;
    flush = 1'b0;

    // flush wins over req in IDLE
    @(negedge clk);
    req = 1'b1; flush = 1'b1; op = 3'b000;
    a = 64'd50; b = 64'd5;
    #1;
    chk1("idle_flush_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    chk1("idle_flush_valid", div_valid, 1'b0);
    chk1("idle_flush_done", done, 1'b0);
    req = 1'b0;
    flush = 1'b0;

    // async reset mid-RUN
    lat_force = 20;
    @(negedge clk);
    req = 1'b1; op = 3'b000; a = 64'd1000; b = 64'd3;
    repeat (2) @(negedge clk);
    #1;
    chk1("mid_run_valid", div_valid, 1'b1);
    reset = 1'b1;
    req = 1'b0;
    #1;
    chk1("arst_valid", div_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk64("arst_div_a", div_a, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done || div_valid) bad = 1'b1;
    end
    chk1("arst_quiet", bad, 1'b0);
    lat_force = -1;
    run_op(3'b000, 64'd1000, 64'd3, r);
    chk64("after_reset", r, 64'd333);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      logic [63:0] x, y;
      int sel;
      o = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 7));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case (sel)
        0: y = 64'd0;
        1: y = '1;
        2: begin x = MIN64; y = '1; end
        3: begin
          x = {$urandom, 32'h8000_0000};
          y = {$urandom, 32'hFFFF_FFFF};
        end
        4: y = 64'($urandom_range(1, 1000));
        5: y = {32'd0, 32'($urandom_range(0, 3))};
        default: ;
      endcase
      run_op(o, x, y, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
